conv1_ctrl: RTL and testbench

//   Frame sequencer for the conv1 stage: 5x5 window line buffer plus 3-channel MAC.
//   - Accepts a raster pixel stream with a valid/ready handshake.
//   - Generates the line-buffer shift enable and tracks row/col position.
//   - Asserts the window-valid strobe that feeds the MAC's valid input, tagged with output coordinates.
//   - Applies downstream backpressure and signals end of frame.

---
 rtl/conv1_ctrl.sv | 163 ++++++++++++++++
 tb/tb_conv1_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_ctrl.sv
// conv1_ctrl: frame sequencer for the conv1 stage (5x5 line buffer + 3-channel MAC).
// Accepts a raster pixel stream, drives the line-buffer shift, tracks the pixel
// position and raises a window-valid strobe tagged with output-map coordinates.
// Downstream backpressure stalls the input side; frame_done pulses once per frame.
// Optional feature macro: CONV1_CTRL_PERF_EN (16-bit saturating stall counter).
module conv1_ctrl #(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int FILTER_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      shift_en,
  input  logic                      out_ready,
  output logic                      win_valid,
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               stall_cnt
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_OFF  = RW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] COL_OFF  = CW'(FILTER_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Position of the next pixel to be accepted (stage 0)
  logic [RW-1:0] row_p0;
  logic [CW-1:0] col_p0;

  // Window strobe and its coordinates (stage 1, aligned with the buffer shift)
  logic          vld_p1;
  logic [RW-1:0] win_row_p1;
  logic [CW-1:0] win_col_p1;

  logic start_acc;
  logic last_pix;
  logic win_pix;

  // Handshake: accept only while running and no unconsumed window is blocking
  assign in_ready  = (state == S_RUN) & (~vld_p1 | out_ready);
  assign shift_en  = in_valid & in_ready;
  assign start_acc = (state == S_IDLE) & start;
  assign last_pix  = (row_p0 == ROW_LAST) & (col_p0 == COL_LAST);
  assign win_pix   = (row_p0 >= ROW_OFF) & (col_p0 >= COL_OFF);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: the last accepted pixel moves to DRAIN so the final
  // window can be consumed before the done pulse
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (shift_en && last_pix) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!vld_p1 || out_ready) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Raster position of the incoming pixel; cleared at frame start and after the last pixel
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (shift_en) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= last_pix ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // ---- stage 0 -> stage 1: window completes on the same edge the buffer shifts ----
  // A new window always wins over consumption; otherwise out_ready retires it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      win_row_p1 <= '0;
      win_col_p1 <= '0;
    end else if (shift_en && win_pix) begin
      vld_p1     <= 1'b1;
      win_row_p1 <= row_p0 - ROW_OFF;
      win_col_p1 <= col_p0 - COL_OFF;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign win_valid  = vld_p1;
  assign win_row    = win_row_p1;
  assign win_col    = win_col_p1;
  assign busy       = (state == S_RUN) | (state == S_DRAIN);
  assign frame_done = (state == S_DONE);

`ifdef CONV1_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_p0;
  logic        stall_evt;

  assign stall_evt = (state == S_RUN) & in_valid & ~in_ready;

  // Stall counter: counts upstream-offered cycles blocked by backpressure; holds after the frame
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_p0 <= 16'd0;
    end else if (stall_evt) begin
      stall_p0 <= sat_inc16(stall_p0);
    end
  end

  assign stall_cnt = stall_p0;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_conv1_ctrl.sv
// Scoreboard bench for conv1_ctrl: the driver pushes the expected raster window
// list at each frame start; a negedge monitor pops and compares whenever the DUT
// presents a window, and tracks frame-level behaviour from the handshake rules.
module tb_conv1_ctrl;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int F    = 5;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - F + 1) * (H - F + 1);
  localparam int LIMIT = 20000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 shift_en;
  logic                 win_valid;
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;
  logic                 busy;
  logic                 frame_done;
  logic [15:0]          stall_cnt;

  conv1_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(F)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .out_ready(out_ready), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; } win_t;
  win_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int acc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  int   m_k = 0;
  bit   m_run = 0, m_drain = 0, m_done_nxt = 0;
  bit   m_prev_wv = 0, m_prev_ordy = 0, m_prev_winpix = 0, m_prev_rst = 1;
  int   m_stall = 0, m_wincnt = 0, m_frames = 0;
  win_t m_last;

  always @(negedge clk) begin
    if (rst) begin
      m_k = 0; m_run = 0; m_drain = 0; m_done_nxt = 0;
      m_prev_wv = 0; m_prev_ordy = 0; m_prev_winpix = 0;
      m_stall = 0; m_wincnt = 0; m_prev_rst = 1;
    end else begin
      bit nd;
      if (m_prev_rst) begin
        check("rst_win_row", int'(win_row), 0);
        check("rst_win_col", int'(win_col), 0);
      end
      check("shift_en", int'(shift_en), int'(in_valid & in_ready));
      check("in_ready", int'(in_ready), (m_run && (!win_valid || out_ready)) ? 1 : 0);
      check("busy", int'(busy), (m_run || m_drain) ? 1 : 0);
      check("frame_done", int'(frame_done), int'(m_done_nxt));
      if (m_prev_winpix) begin
        check("win_valid_new", int'(win_valid), 1);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL win_unexpected actual=(%0d,%0d) required=none", win_row, win_col);
        end else begin
          m_last = exp_q.pop_front();
          check("win_row", int'(win_row), m_last.r);
          check("win_col", int'(win_col), m_last.c);
          m_wincnt++;
        end
      end else if (m_prev_wv && !m_prev_ordy) begin
        check("hold_valid", int'(win_valid), 1);
        check("hold_row", int'(win_row), m_last.r);
        check("hold_col", int'(win_col), m_last.c);
      end else begin
        check("win_valid_low", int'(win_valid), 0);
      end
`ifdef CONV1_CTRL_PERF_EN
      check("stall_cnt", int'(stall_cnt), m_stall);
`else
      check("stall_cnt", int'(stall_cnt), 0);
`endif
      if (m_done_nxt) begin
        check("win_count", m_wincnt, NWIN);
        check("exp_q_empty", exp_q.size(), 0);
        m_frames++;
      end
      // model updates for the next cycle
      nd = m_drain && (!win_valid || out_ready);
      if (nd) m_drain = 0;
      if (m_run && in_valid && !in_ready && m_stall < 65535) m_stall++;
      m_prev_winpix = 0;
      if (shift_en) begin
        int r, c;
        r = m_k / W;
        c = m_k % W;
        m_prev_winpix = (r >= F - 1) && (c >= F - 1);
        m_k++;
        if (m_k == NPIX) begin
          m_run = 0;
          m_drain = 1;
        end
      end
      if (start && !busy && !frame_done) begin
        m_run = 1; m_k = 0; m_stall = 0; m_wincnt = 0;
      end
      m_done_nxt  = nd;
      m_prev_wv   = win_valid;
      m_prev_ordy = out_ready;
      m_prev_rst  = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    if (shift_en) acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_win_row"}, int'(win_row), 0);
    check({tag, "_win_col"}, int'(win_col), 0);
    check({tag, "_stall_cnt"}, int'(stall_cnt), 0);
  endtask

  task automatic begin_frame();
    win_t w;
    start = 1'b1;
    for (int r = 0; r <= H - F; r++) begin
      for (int c = 0; c <= W - F; c++) begin
        w.r = r;
        w.c = c;
        exp_q.push_back(w);
      end
    end
    acc = 0;
    tick();
    start = 1'b0;
  endtask

  // mode 0: full rate; 1: backpressure holds; 2: toggling valid;
  // 3: random traffic + ignored starts; 4: reset after pixel #300
  task automatic run_frame(input int mode);
    int cyc = 0;
    int dr = 0;
    bit d57 = 0;
    bit d103 = 0;
    int s0;
    begin_frame();
    while (!frame_done && cyc < LIMIT) begin
      case (mode)
        1: begin
          in_valid = 1'b1;
          out_ready = 1'b1;
          if (!d57 && win_valid && win_row == 5 && win_col == 7) begin
            d57 = 1;
            out_ready = 1'b0;
            repeat (10) tick();
            check("t2_hold_valid", int'(win_valid), 1);
            check("t2_hold_row", int'(win_row), 5);
            check("t2_hold_col", int'(win_col), 7);
            check("t2_in_ready", int'(in_ready), 0);
            out_ready = 1'b1;
          end else if (!d103 && win_valid && win_row == 10 && win_col == 3) begin
            d103 = 1;
            s0 = int'(stall_cnt);
            out_ready = 1'b0;
            repeat (20) tick();
`ifdef CONV1_CTRL_PERF_EN
            check("t6_stall_cnt", int'(stall_cnt), s0 + 20);
`else
            check("t6_stall_cnt", int'(stall_cnt), 0);
`endif
            out_ready = 1'b1;
          end
        end
        2: begin
          in_valid = (cyc % 2 == 0);
          out_ready = 1'b1;
        end
        3: begin
          if (acc == NPIX) begin
            in_valid = 1'b0;
            start = (dr == 0 || dr == 2);
            out_ready = (dr >= 3);
            dr++;
          end else begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            start = busy && ($urandom_range(0, 15) == 0);
          end
        end
        4: begin
          in_valid = 1'b1;
          out_ready = 1'b1;
          if (acc == 301) begin
            rst = 1'b1;
            exp_q.delete();
            tick();
            rst = 1'b0;
            in_valid = 1'b0;
            check_reset_vals("t4");
            return;
          end
        end
        default: begin
          in_valid = 1'b1;
          out_ready = 1'b1;
        end
      endcase
      tick();
      cyc++;
    end
    if (cyc >= LIMIT) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout mode=%0d cycles=%0d required_below=%0d", mode, cyc, LIMIT);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(0);
    repeat (3) tick();
    check("frames_done", m_frames, 5);
    check("exp_q_final", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
